// File: rtl/lc3b_types.sv
// lc3b shared types.
// Word type, predictor index mode, counter reset value.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic {
    BP_BIMODAL = 1'b0,
    BP_GSHARE  = 1'b1
  } bp_mode_t;

  // Weakly-not-taken value for an n-bit saturating counter.
  function automatic int bp_wnt(input int bits);
    return (1 << (bits - 1)) - 1;
  endfunction

endpackage

// File: rtl/sat_counter_array.sv
// Table of saturating counters.
// One combinational read port, one inc/dec write port.
module sat_counter_array
  import lc3b_types::*;
#(
  parameter int ENTRIES = 64,
  parameter int BITS    = 2,
  localparam int IW     = $clog2(ENTRIES)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [IW-1:0]   rd_idx,
  output logic [BITS-1:0] rd_data,
  input  logic            wr_en,
  input  logic [IW-1:0]   wr_idx,
  input  logic            wr_inc
);

  localparam logic [BITS-1:0] INIT = BITS'(bp_wnt(BITS));
  localparam logic [BITS-1:0] MAX  = '1;

  logic [BITS-1:0] mem [ENTRIES];

  assign rd_data = mem[rd_idx];

  // Saturating train of one counter; reset loads weakly-not-taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++)
        mem[i] <= INIT;
    end else if (wr_en) begin
      if (wr_inc && mem[wr_idx] != MAX)
        mem[wr_idx] <= mem[wr_idx] + 1'b1;
      else if (!wr_inc && mem[wr_idx] != '0)
        mem[wr_idx] <= mem[wr_idx] - 1'b1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage predictor: direct-mapped BTB,
// counter table, optional gshare, stats.
module branch_predictor
  import lc3b_types::*;
#(
  parameter int BTB_ENTRIES = 16,
  parameter int PHT_ENTRIES = 64,
  parameter int CTR_BITS    = 2,
  parameter int GHR_BITS    = 4,
  parameter int MODE        = 0,
  localparam int PI_W       = $clog2(PHT_ENTRIES)
) (
  input  logic            clk,
  input  logic            reset,
  input  lc3b_word        fetch_pc,
  output logic            btb_hit,
  output logic            btb_uc,
  output logic            pred_taken,
  output lc3b_word        pred_target,
  output logic [PI_W-1:0] pred_idx,
  input  logic            upd_valid,
  input  lc3b_word        upd_pc,
  input  logic [PI_W-1:0] upd_idx,
  input  logic            upd_uc,
  input  logic            upd_taken,
  input  lc3b_word        upd_target,
  input  logic            upd_pred_taken,
  input  lc3b_word        upd_pred_target,
  output logic            mispredict,
  output logic [15:0]     br_count,
  output logic [15:0]     mp_count
);

  localparam int  BI_W  = $clog2(BTB_ENTRIES);
  localparam int  TAG_W = 15 - BI_W;
  localparam bit  GSH   = (MODE == int'(BP_GSHARE));

  logic [BTB_ENTRIES-1:0] btb_valid;
  logic [BTB_ENTRIES-1:0] btb_ucb;
  logic [TAG_W-1:0]       btb_tag [BTB_ENTRIES];
  lc3b_word               btb_tgt [BTB_ENTRIES];

  logic [GHR_BITS-1:0] ghr;
  logic [CTR_BITS-1:0] ctr;
  logic [BI_W-1:0]     f_bi;
  logic [BI_W-1:0]     u_bi;
  logic                train;
  logic                alloc;
  logic                unused_bits;

  assign unused_bits = fetch_pc[0] ^ upd_pc[0];

  assign f_bi  = fetch_pc[BI_W:1];
  assign u_bi  = upd_pc[BI_W:1];
  assign train = upd_valid & ~upd_uc;
  assign alloc = upd_valid & upd_taken;

  assign btb_hit = btb_valid[f_bi] &&
                   btb_tag[f_bi] == fetch_pc[15:BI_W+1];
  assign btb_uc  = btb_hit & btb_ucb[f_bi];
  assign pred_taken  = btb_hit & (btb_uc | ctr[CTR_BITS-1]);
  assign pred_target = btb_hit ? btb_tgt[f_bi] : '0;

  assign pred_idx = fetch_pc[PI_W:1] ^
                    (GSH ? PI_W'(ghr) : '0);

  assign mispredict = upd_valid &
    ((upd_taken != upd_pred_taken) |
     (upd_taken & (upd_target != upd_pred_target)));

  sat_counter_array #(
    .ENTRIES (PHT_ENTRIES),
    .BITS    (CTR_BITS)
  ) u_pht (
    .clk     (clk),
    .reset   (reset),
    .rd_idx  (pred_idx),
    .rd_data (ctr),
    .wr_en   (train),
    .wr_idx  (upd_idx),
    .wr_inc  (upd_taken)
  );

  // BTB valid/uc: cleared on reset, set on taken resolve.
  always_ff @(posedge clk) begin
    if (reset) begin
      btb_valid <= '0;
      btb_ucb   <= '0;
    end else if (alloc) begin
      btb_valid[u_bi] <= 1'b1;
      btb_ucb[u_bi]   <= upd_uc;
    end
  end

  // BTB tag/target payload; only meaningful when valid.
  always_ff @(posedge clk) begin
    if (!reset && alloc) begin
      btb_tag[u_bi] <= upd_pc[15:BI_W+1];
      btb_tgt[u_bi] <= upd_target;
    end
  end

  // Non-speculative history of conditional outcomes.
  always_ff @(posedge clk) begin
    if (reset)
      ghr <= '0;
    else if (train)
      ghr <= GHR_BITS'({ghr, upd_taken});
  end

  // Saturating branch and mispredict statistics.
  always_ff @(posedge clk) begin
    if (reset) begin
      br_count <= '0;
      mp_count <= '0;
    end else if (upd_valid) begin
      if (br_count != 16'hFFFF)
        br_count <= br_count + 16'd1;
      if (mispredict && mp_count != 16'hFFFF)
        mp_count <= mp_count + 16'd1;
    end
  end

endmodule
